// File: rtl/clk_pkg.sv
// Shared types and default timing constants for the clock front-end blocks.
package clk_pkg;

   // Per-button hold/auto-repeat state.
   typedef enum logic [1:0] {
      IDLE,
      HELD,
      REPEAT
   } btn_state_t;

   // Defaults assume a 100 MHz system clock and a 1 kHz sample tick.
   localparam int unsigned DEF_NUM_BTN      = 5;
   localparam int unsigned DEF_TICK_DIV     = 100000;
   localparam int unsigned DEF_DEB_TICKS    = 10;
   localparam int unsigned DEF_HOLD_TICKS   = 500;
   localparam int unsigned DEF_REPEAT_TICKS = 100;

   // Width of a counter that must be able to hold the value 'limit'.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debouncer and the
// press / release / auto-repeat state machine. All outputs are registered.
module btn_channel
   import clk_pkg::*;
#(
   parameter int unsigned DEB_TICKS    = DEF_DEB_TICKS,
   parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
   parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic press,
   output logic rel,
   output logic rep,
   output logic long_hold
);

   localparam int unsigned DW = cnt_width(DEB_TICKS);
   localparam int unsigned HW = cnt_width(HOLD_TICKS);
   localparam int unsigned RW = cnt_width(REPEAT_TICKS);

   // A counter holding the *_LAST value decides on the next tick.
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

   logic          sync_meta;
   logic          sync;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] rep_cnt;
   logic          flip;
   logic          rise;
   logic          fall;
   btn_state_t    state;

   // Bring the raw asynchronous input into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= btn;
         sync      <= sync_meta;
      end
   end

   // Decide on this tick whether the debounced level changes, so the FSM
   // can raise its strobes in the same cycle the level register moves.
   always_comb begin
      flip = tick && (sync != level) && (deb_cnt >= DEB_LAST);
      rise = flip && !level;
      fall = flip && level;
   end

   // Debounce: count consecutive disagreeing ticks, toggle level at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt <= '0;
         level   <= 1'b0;
      end else if (tick) begin
         if (sync != level) begin
            if (deb_cnt >= DEB_LAST) begin
               level   <= ~level;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Press / hold / auto-repeat FSM with registered single-cycle strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         press     <= 1'b0;
         rel       <= 1'b0;
         rep       <= 1'b0;
         long_hold <= 1'b0;
      end else begin
         press <= 1'b0;
         rel   <= 1'b0;
         rep   <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  press    <= 1'b1;
                  rep      <= 1'b1;
                  hold_cnt <= '0;
                  state    <= HELD;
               end
            end
            HELD: begin
               if (fall) begin
                  rel   <= 1'b1;
                  state <= IDLE;
               end else if (tick) begin
                  if (hold_cnt >= HOLD_LAST) begin
                     rep       <= 1'b1;
                     long_hold <= 1'b1;
                     rep_cnt   <= '0;
                     state     <= REPEAT;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            REPEAT: begin
               // A release on a repeat tick wins: no rep in that cycle.
               if (fall) begin
                  rel       <= 1'b1;
                  long_hold <= 1'b0;
                  state     <= IDLE;
               end else if (tick) begin
                  if (rep_cnt >= REP_LAST) begin
                     rep     <= 1'b1;
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               long_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: shared sample-tick generator plus
// one btn_channel per button. The release strobe port is named 'rel'
// because 'release' is a reserved word in SystemVerilog.
module btn_conditioner
   import clk_pkg::*;
#(
   parameter int unsigned NUM_BTN      = DEF_NUM_BTN,
   parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
   parameter int unsigned DEB_TICKS    = DEF_DEB_TICKS,
   parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
   parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] level,
   output logic [NUM_BTN-1:0] press,
   output logic [NUM_BTN-1:0] rel,
   output logic [NUM_BTN-1:0] rep,
   output logic [NUM_BTN-1:0] long_hold
);

   localparam int unsigned     TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;

   // Shared sample tick: one registered pulse each time the divider wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         tick     <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_channel #(
         .DEB_TICKS    (DEB_TICKS),
         .HOLD_TICKS   (HOLD_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .btn       (btn[i]),
         .level     (level[i]),
         .press     (press[i]),
         .rel       (rel[i]),
         .rep       (rep[i]),
         .long_hold (long_hold[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: per-cycle scoreboard against a tick-level
// reference model, a table of stimulus rows with expected strobe counts,
// and hand-written sequences for simultaneous release and mid-hold reset.
module tb_btn_conditioner;

   localparam int NB = 5;
   localparam int TD = 4;
   localparam int DB = 3;
   localparam int HT = 8;
   localparam int RT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn = 5'b11111;
   logic [NB-1:0] level, press, rel, rep, long_hold;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   btn_conditioner #(
      .NUM_BTN      (NB),
      .TICK_DIV     (TD),
      .DEB_TICKS    (DB),
      .HOLD_TICKS   (HT),
      .REPEAT_TICKS (RT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .level     (level),
      .press     (press),
      .rel       (rel),
      .rep       (rep),
      .long_hold (long_hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
         end
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] rep;
      logic [NB-1:0] long_hold;
   } obs_t;

   obs_t          sb_q[$];
   int            m_cnt;
   logic          m_tick;
   logic [NB-1:0] m_s1, m_s2, m_lev, m_lh;
   int            m_run[NB];
   int            m_held[NB];

   always @(posedge clk or posedge rst) begin
      obs_t e;
      bit   toggled;
      e = '0;
      if (rst) begin
         m_cnt  = 0;
         m_tick = 1'b0;
         m_s1   = '0;
         m_s2   = '0;
         m_lev  = '0;
         m_lh   = '0;
         for (int ch = 0; ch < NB; ch++) begin
            m_run[ch]  = 0;
            m_held[ch] = 0;
         end
      end else begin
         for (int ch = 0; ch < NB; ch++) begin
            toggled = 1'b0;
            if (m_tick) begin
               if (m_s2[ch] != m_lev[ch]) begin
                  m_run[ch]++;
                  if (m_run[ch] == DB) begin
                     m_run[ch]  = 0;
                     m_lev[ch]  = ~m_lev[ch];
                     toggled    = 1'b1;
                     if (m_lev[ch]) begin
                        e.press[ch] = 1'b1;
                        e.rep[ch]   = 1'b1;
                        m_held[ch]  = 0;
                     end else begin
                        e.rel[ch] = 1'b1;
                        m_lh[ch]  = 1'b0;
                     end
                  end
               end else begin
                  m_run[ch] = 0;
               end
               if (!toggled && m_lev[ch]) begin
                  m_held[ch]++;
                  if (m_held[ch] == HT) begin
                     e.rep[ch] = 1'b1;
                     m_lh[ch]  = 1'b1;
                  end else if (m_held[ch] > HT && ((m_held[ch] - HT) % RT) == 0) begin
                     e.rep[ch] = 1'b1;
                  end
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = btn;
         if (m_cnt == TD - 1) begin
            m_cnt  = 0;
            m_tick = 1'b1;
         end else begin
            m_cnt++;
            m_tick = 1'b0;
         end
      end
      e.level     = m_lev;
      e.long_hold = m_lh;
      sb_q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e;
      obs_t got;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got no expectation required one at %0t", $time);
      end else begin
         while (sb_q.size() > 0) e = sb_q.pop_front();
         got = '{level, press, rel, rep, long_hold};
         chk("sb_cycle", 32'(got), 32'(e));
      end
   end

   // ---------------- stimulus table ----------------
   typedef struct {
      logic [NB-1:0]      btn;
      int                 cycles;
      logic [NB-1:0]      press_m;
      logic [NB-1:0]      rel_m;
      logic [NB-1:0][3:0] rep_n;
      logic [NB-1:0]      lev_end;
      logic [NB-1:0]      lh_end;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0][3:0] c_press, c_rel, c_rep, e_press, e_rel;
      logic [NB-1:0]      l_end, h_end;
      bit                 found;
      int                 lat;

      // held through reset; debounced press, 7 ticks, no auto-repeat yet
      tbl[0] = '{5'b11111, 28, 5'b11111, 5'b00000, {4'd1,4'd1,4'd1,4'd1,4'd1}, 5'b11111, 5'b00000};
      tbl[1] = '{5'b00000, 24, 5'b00000, 5'b11111, {4'd0,4'd0,4'd0,4'd0,4'd0}, 5'b00000, 5'b00000};
      // 2-tick glitch on btn[0]
      tbl[2] = '{5'b00001,  8, 5'b00000, 5'b00000, {4'd0,4'd0,4'd0,4'd0,4'd0}, 5'b00000, 5'b00000};
      tbl[3] = '{5'b00000, 12, 5'b00000, 5'b00000, {4'd0,4'd0,4'd0,4'd0,4'd0}, 5'b00000, 5'b00000};
      // clean press/release of btn[3]
      tbl[4] = '{5'b01000, 20, 5'b01000, 5'b00000, {4'd0,4'd1,4'd0,4'd0,4'd0}, 5'b01000, 5'b00000};
      tbl[5] = '{5'b00000, 24, 5'b00000, 5'b01000, {4'd0,4'd0,4'd0,4'd0,4'd0}, 5'b00000, 5'b00000};
      // 30-tick hold of btn[4]: press + reps at +8,+12,+16,+20,+24 ticks
      tbl[6] = '{5'b10000, 120, 5'b10000, 5'b00000, {4'd6,4'd0,4'd0,4'd0,4'd0}, 5'b10000, 5'b10000};
      // one more rep (+28) lands during release debounce
      tbl[7] = '{5'b00000, 24, 5'b00000, 5'b10000, {4'd1,4'd0,4'd0,4'd0,4'd0}, 5'b00000, 5'b00000};

      rst = 1'b1;
      btn = 5'b11111;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("reset_outputs", 32'({level, press, rel, rep, long_hold}), 32'd0);
      end
      @(posedge clk);
      #2 rst = 1'b0;

      for (int r = 0; r < 8; r++) begin
         btn     = tbl[r].btn;
         c_press = '0;
         c_rel   = '0;
         c_rep   = '0;
         l_end   = '0;
         h_end   = '0;
         for (int c = 0; c < tbl[r].cycles; c++) begin
            @(negedge clk);
            for (int ch = 0; ch < NB; ch++) begin
               c_press[ch] = c_press[ch] + 4'(press[ch]);
               c_rel[ch]   = c_rel[ch]   + 4'(rel[ch]);
               c_rep[ch]   = c_rep[ch]   + 4'(rep[ch]);
            end
            l_end = level;
            h_end = long_hold;
            @(posedge clk);
            #2;
         end
         for (int ch = 0; ch < NB; ch++) begin
            e_press[ch] = {3'b000, tbl[r].press_m[ch]};
            e_rel[ch]   = {3'b000, tbl[r].rel_m[ch]};
         end
         chk($sformatf("row%0d_press_cnt", r), 32'(c_press), 32'(e_press));
         chk($sformatf("row%0d_rel_cnt", r),   32'(c_rel),   32'(e_rel));
         chk($sformatf("row%0d_rep_cnt", r),   32'(c_rep),   32'(tbl[r].rep_n));
         chk($sformatf("row%0d_level", r),     32'(l_end),   32'(tbl[r].lev_end));
         chk($sformatf("row%0d_long_hold", r), 32'(h_end),   32'(tbl[r].lh_end));
      end

      // Simultaneous press on btn[0] and btn[1].
      btn   = 5'b00011;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (press != '0) begin
            found = 1'b1;
            break;
         end
      end
      chk("simul_press_seen", 32'(found), 32'd1);
      chk("simul_press", 32'(press), 32'h03);

      // Wait until channel 0 is auto-repeating.
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rep[0] && long_hold[0]) begin
            found = 1'b1;
            break;
         end
      end
      chk("repeat_entry_seen", 32'(found), 32'd1);

      // Time the btn[1] release so its debounced fall lands on a repeat tick.
      @(posedge clk);
      repeat (4) @(posedge clk);
      #2 btn = 5'b00001;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rel != '0) begin
            found = 1'b1;
            break;
         end
      end
      chk("rel1_seen", 32'(found), 32'd1);
      chk("rel1_only", 32'(rel), 32'h02);
      chk("rel1_rep_same_cycle", 32'(rep), 32'h01);
      chk("rel1_level", 32'(level), 32'h01);
      chk("rel1_long_hold", 32'(long_hold), 32'h01);

      // Reset while channel 0 is in REPEAT.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_clear", 32'({level, press, rel, rep, long_hold}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_clear", 32'({level, press, rel, rep, long_hold}), 32'd0);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (rel != '0) chk("rst_no_release", 32'(rel), 32'd0);
         if (press != '0) begin
            found = 1'b1;
            lat   = i;
            break;
         end
      end
      chk("repress_seen", 32'(found), 32'd1);
      chk("repress_latency", 32'(lat), 32'd14);
      chk("repress_vec", 32'(press), 32'h01);
      chk("repress_level", 32'(level), 32'h01);

      repeat (8) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
